// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types, constants and 7-segment table for the score display
package tetris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter (shift-add-3)
module bin2bcd_seq
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t state;
  logic [3:0]  cnt;
  logic [13:0] sr;
  logic [15:0] acc;
  logic [15:0] adj;

  // Add 3 to any BCD nibble >= 5 before it is doubled by the shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr    <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr    <= bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= {adj[14:0], sr[13]};
          sr  <= {sr[12:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13) begin
            done  <= 1'b1;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 4-digit multiplexed 7-segment score display with blink
module score_display_driver
  import tetris_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100_000,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score,
  input  logic        score_valid,
  input  logic        win,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy
);

  localparam int RW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  logic          pend_valid;
  logic [13:0]   pend_value;
  logic          conv_start;
  logic          conv_busy;
  logic          conv_done;
  logic [15:0]   conv_bcd;
  logic [15:0]   disp;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [3:0]    show;
  logic [3:0]    cur_digit;

  // The pending slot doubles as the launch register, so a strobe in any
  // converter state (including COMMIT) is kept and the latest one wins.
  assign conv_start = pend_valid && !conv_busy;
  assign busy       = pend_valid || conv_busy;
  assign dp         = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_value <= '0;
    end else if (score_valid) begin
      pend_valid <= 1'b1;
      pend_value <= (score > SCORE_MAX) ? SCORE_MAX : score;
    end else if (conv_start) begin
      pend_valid <= 1'b0;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (pend_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         disp <= '0;
    else if (conv_done) disp <= conv_bcd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RW'(DIGIT_PERIOD - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!win) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A digit is lit if it or any more-significant digit is nonzero; ones always lit.
  assign show[3]   = (disp[15:12] != 4'd0);
  assign show[2]   = show[3] || (disp[11:8] != 4'd0);
  assign show[1]   = show[2] || (disp[7:4] != 4'd0);
  assign show[0]   = 1'b1;
  assign cur_digit = disp[digit_idx*4 +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else if (blink_off || !show[digit_idx]) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_code(cur_digit);
      an  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - self-checking bench for score_display_driver
module tb_score_display_driver;

  localparam int DP = 4;
  localparam int BP = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic        win = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  score_display_driver #(.DIGIT_PERIOD(DP), .BLINK_PERIOD(BP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .win         (win),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input int v);
    score       = 14'(v);
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      step();
    end
    if (n >= 300) chk({tag, "_timeout"}, n, 0);
  endtask

  // Watch 16 cycles (4 full scan slots) and tally what each anode showed.
  task automatic check_display(input string tag, input int v);
    int cnt[4];
    int dig[4];
    int bad;
    int blanks;
    int hidden;
    bit lit;
    bad = 0;
    blanks = 0;
    hidden = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      dig[i] = (v / (10 ** i)) % 10;
    end
    for (int c = 0; c < 4 * DP; c++) begin
      case (an)
        4'b1110: begin cnt[0]++; if (int'(seg) != seg_ref(dig[0])) bad++; end
        4'b1101: begin cnt[1]++; if (int'(seg) != seg_ref(dig[1])) bad++; end
        4'b1011: begin cnt[2]++; if (int'(seg) != seg_ref(dig[2])) bad++; end
        4'b0111: begin cnt[3]++; if (int'(seg) != seg_ref(dig[3])) bad++; end
        4'b1111: blanks++;
        default: bad++;
      endcase
      step();
    end
    for (int i = 3; i >= 0; i--) begin
      lit = (i == 0) || (v >= 10 ** i);
      if (!lit) hidden++;
      chk($sformatf("%s_slot%0d", tag, i), cnt[i], lit ? DP : 0);
    end
    chk({tag, "_segbad"}, bad, 0);
    chk({tag, "_blanks"}, blanks, hidden * DP);
  endtask

  initial begin
    int n;
    int offs;
    int run;
    int max_run;
    int fives;
    int expv;

    // Reset state
    step();
    chk("rst_an", int'(an), 4'hF);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dp", int'(dp), 1);
    rst_n = 1'b1;
    step();
    chk("post_rst_an", int'(an), 4'b1110);
    chk("post_rst_seg", int'(seg), 7'b1000000);
    check_display("zero", 0);

    // 1234: busy length and digit order
    pulse(1234);
    exp_q.push_back(1234);
    wait_idle("c1234", n);
    chk("busy_len", n, 16);
    step();
    expv = exp_q.pop_front();
    check_display("d1234", expv);

    // Clamp
    pulse(14'h3FFF);
    exp_q.push_back(9999);
    wait_idle("c3fff", n);
    chk("busy_len_clamp", n, 16);
    step();
    expv = exp_q.pop_front();
    check_display("d9999", expv);

    // Blink while win is high
    win = 1'b1;
    offs = 0;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 4 * BP; i++) begin
      step();
      if (an == 4'hF) begin
        offs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    chk("blink_off_total", offs, 2 * BP);
    chk("blink_off_run", max_run, BP);
    repeat (37) step();
    chk("blink_off_phase", int'(an), 4'hF);
    win = 1'b0;
    step();
    step();
    chk("blink_resume", int'(an != 4'hF), 1);

    // Strobes while busy: only the latest survives
    pulse(7);
    step();
    step();
    pulse(50);
    step();
    step();
    step();
    pulse(908);
    exp_q.push_back(908);
    n = 0;
    fives = 0;
    while (busy && n < 300) begin
      if (an == 4'b1101 && int'(seg) == seg_ref(5)) fives++;
      n++;
      step();
    end
    if (n >= 300) chk("pend_timeout", n, 0);
    step();
    expv = exp_q.pop_front();
    check_display("d908", expv);
    chk("no_fifty", fives, 0);

    // Reset at SHIFT cycle 7 of a 4321 conversion
    pulse(4321);
    repeat (7) step();
    chk("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", int'(an), 4'hF);
    chk("mid_rst_seg", int'(seg), 7'h7F);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_dp", int'(dp), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_an", int'(an), 4'b1110);
    chk("mid_post_seg", int'(seg), 7'b1000000);
    check_display("mid_zero", 0);
    repeat (20) step();
    chk("mid_busy_after", int'(busy), 0);
    check_display("mid_zero_late", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
